// File: rtl/game_session_ctrl.sv
// game_session_ctrl: round state, countdown, magazine, scoring and sound-event control for duck hunt
module game_session_ctrl #(
  parameter int NUM_DUCKS     = 4,
  parameter int MAG_SIZE      = 4,
  parameter int AMMO_W        = 3,
  parameter int ROUND_SECS    = 30,
  parameter int TICKS_PER_SEC = 24000000,
  parameter int TICK_W        = 25,
  parameter int SCORE_W       = 8,
  parameter int SOUND_HOLD    = 2000000,
  parameter int HOLD_W        = 21,
  parameter int AUTO_START    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 fire,
  input  logic                 reload,
  input  logic [NUM_DUCKS-1:0] collision,
  output logic [1:0]           state,
  output logic                 game_over,
  output logic                 shot_pulse,
  output logic [AMMO_W-1:0]    ammo,
  output logic [SCORE_W-1:0]   score,
  output logic [7:0]           secs_left,
  output logic [1:0]           tone_sel
);
  localparam int HIT_W = $clog2(NUM_DUCKS + 1);
  localparam int SUM_W = ((SCORE_W > HIT_W) ? SCORE_W : HIT_W) + 1;
  localparam logic [AMMO_W-1:0]  MAG  = AMMO_W'(MAG_SIZE);
  localparam logic [7:0]         SECS = 8'(ROUND_SECS);
  localparam logic [HOLD_W-1:0]  HOLD = HOLD_W'(SOUND_HOLD - 1);
  localparam logic [TICK_W-1:0]  LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [SCORE_W-1:0] SMAX = '1;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  state_t               r_state, w_state_n;
  logic                 r_fire_d, r_start_d, r_game_over, r_shot, w_shot_n;
  logic [NUM_DUCKS-1:0] r_coll_d;
  logic [TICK_W-1:0]    r_tick, w_tick_n;
  logic [HOLD_W-1:0]    r_hold, w_hold_n;
  logic [AMMO_W-1:0]    r_ammo, w_ammo_n;
  logic [SCORE_W-1:0]   r_score, w_score_n, w_score_sat;
  logic [7:0]           r_secs, w_secs_n;
  logic [1:0]           r_tone, w_tone_n;
  logic [HIT_W-1:0]     w_hits;
  logic [SUM_W-1:0]     w_sum;
  logic                 w_fire_rise, w_start_rise, w_wrap;
  assign w_fire_rise  = fire & ~r_fire_d;
  assign w_start_rise = start & ~r_start_d;
  assign w_wrap       = r_tick == LAST;
  assign w_sum        = SUM_W'(r_score) + SUM_W'(w_hits);
  assign w_score_sat  = (w_sum > SUM_W'(SMAX)) ? SMAX : w_sum[SCORE_W-1:0];
  assign state        = r_state;
  assign game_over    = r_game_over;
  assign shot_pulse   = r_shot;
  assign ammo         = r_ammo;
  assign score        = r_score;
  assign secs_left    = r_secs;
  assign tone_sel     = r_tone;
  // count ducks whose collision just fell: each is one hit
  always_comb begin
    w_hits = '0;
    for (int i = 0; i < NUM_DUCKS; i++) w_hits = w_hits + HIT_W'(r_coll_d[i] & ~collision[i]);
  end
  // next-state and next-output logic; outside PLAY everything freezes except a start rise
  always_comb begin
    w_state_n = r_state;
    w_tick_n  = r_tick;
    w_hold_n  = r_hold;
    w_ammo_n  = r_ammo;
    w_score_n = r_score;
    w_secs_n  = r_secs;
    w_tone_n  = 2'd0;
    w_shot_n  = 1'b0;
    if (r_state != PLAY) begin
      if (w_start_rise) begin
        w_state_n = PLAY;
        w_tick_n  = '0;
        w_hold_n  = '0;
        w_ammo_n  = MAG;
        w_score_n = '0;
        w_secs_n  = SECS;
      end
    end else begin
      w_tick_n  = w_wrap ? '0 : r_tick + 1'b1;
      w_secs_n  = w_wrap ? r_secs - 1'b1 : r_secs;
      w_shot_n  = !reload && w_fire_rise && r_ammo != '0;
      w_ammo_n  = reload ? MAG : w_shot_n ? r_ammo - 1'b1 : r_ammo;
      w_score_n = w_score_sat;
      w_hold_n  = (w_hits != '0 || (w_shot_n && r_tone != 2'd2)) ? HOLD :
                  (r_hold != '0) ? r_hold - 1'b1 : r_hold;
      w_tone_n  = (w_hits != '0) ? 2'd2 :
                  (w_shot_n && r_tone != 2'd2) ? 2'd1 :
                  (r_hold != '0) ? r_tone : 2'd0;
      if (w_wrap && r_secs == 8'd1) begin
        w_state_n = OVER;
        w_tone_n  = 2'd0;
      end
    end
  end
  // state and output registers; edge detectors track inputs in every state
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= (AUTO_START != 0) ? PLAY : IDLE;
      r_game_over <= 1'b0;
      r_shot      <= 1'b0;
      r_ammo      <= MAG;
      r_score     <= '0;
      r_secs      <= SECS;
      r_tone      <= 2'd0;
      r_tick      <= '0;
      r_hold      <= '0;
      r_fire_d    <= 1'b0;
      r_start_d   <= 1'b0;
      r_coll_d    <= '0;
    end else begin
      r_state     <= w_state_n;
      r_game_over <= w_state_n == OVER;
      r_shot      <= w_shot_n;
      r_ammo      <= w_ammo_n;
      r_score     <= w_score_n;
      r_secs      <= w_secs_n;
      r_tone      <= w_tone_n;
      r_tick      <= w_tick_n;
      r_hold      <= w_hold_n;
      r_fire_d    <= fire;
      r_start_d   <= start;
      r_coll_d    <= collision;
    end
  end
endmodule

// File: tb/tb_game_session_ctrl.sv
// tb_game_session_ctrl: directed scoreboard bench for game_session_ctrl
module tb_game_session_ctrl;
  logic       clk = 1'b0, reset = 1'b0, reset0 = 1'b0, start = 1'b0, fire = 1'b0, reload = 1'b0;
  logic [3:0] collision = '0;
  logic [1:0] state, tone_sel, state0, tone_sel0;
  logic       game_over, shot_pulse, game_over0, shot_pulse0;
  logic [2:0] ammo, ammo0;
  logic [1:0] score, score0;
  logic [7:0] secs_left, secs_left0;
  typedef struct {string tag; logic [31:0] val;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  game_session_ctrl #(.NUM_DUCKS(4), .MAG_SIZE(2), .AMMO_W(3), .ROUND_SECS(3), .TICKS_PER_SEC(10),
    .TICK_W(4), .SCORE_W(2), .SOUND_HOLD(4), .HOLD_W(3), .AUTO_START(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .fire(fire), .reload(reload), .collision(collision),
    .state(state), .game_over(game_over), .shot_pulse(shot_pulse), .ammo(ammo), .score(score),
    .secs_left(secs_left), .tone_sel(tone_sel));

  game_session_ctrl #(.NUM_DUCKS(4), .MAG_SIZE(2), .AMMO_W(3), .ROUND_SECS(3), .TICKS_PER_SEC(10),
    .TICK_W(4), .SCORE_W(2), .SOUND_HOLD(4), .HOLD_W(3), .AUTO_START(0)) u_idle (
    .clk(clk), .reset(reset0), .start(start), .fire(fire), .reload(reload), .collision(collision),
    .state(state0), .game_over(game_over0), .shot_pulse(shot_pulse0), .ammo(ammo0), .score(score0),
    .secs_left(secs_left0), .tone_sel(tone_sel0));

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: got %0d but nothing was expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: got %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    push("rst_state", 1); push("rst_go", 0); push("rst_ammo", 2); push("rst_score", 0);
    push("rst_secs", 3); push("rst_tone", 0); push("rst_shot", 0); push("rst0_state", 0);
    step(3);
    pop_cmp(32'(state)); pop_cmp(32'(game_over)); pop_cmp(32'(ammo)); pop_cmp(32'(score));
    pop_cmp(32'(secs_left)); pop_cmp(32'(tone_sel)); pop_cmp(32'(shot_pulse)); pop_cmp(32'(state0));
    // countdown, with a hit landing on the final tick
    reset = 1'b1;
    push("a_secs9", 3); step(9); pop_cmp(32'(secs_left));
    push("a_secs10", 2); step(1); pop_cmp(32'(secs_left));
    push("a_secs20", 1); push("a_state20", 1); step(10); pop_cmp(32'(secs_left)); pop_cmp(32'(state));
    step(8);
    collision = 4'b0001; step(1);
    collision = 4'b0000;
    push("a_secs30", 0); push("a_state30", 2); push("a_go30", 1); push("a_score30", 1); push("a_tone30", 0);
    step(1);
    pop_cmp(32'(secs_left)); pop_cmp(32'(state)); pop_cmp(32'(game_over)); pop_cmp(32'(score)); pop_cmp(32'(tone_sel));
    // OVER ignores hits and shots, then start restarts; start ignored in PLAY
    collision = 4'b1111; step(1);
    collision = 4'b0000; fire = 1'b1;
    push("b_score_over", 1); push("b_ammo_over", 2); push("b_shot_over", 0); push("b_state_over", 2);
    step(1);
    pop_cmp(32'(score)); pop_cmp(32'(ammo)); pop_cmp(32'(shot_pulse)); pop_cmp(32'(state));
    fire = 1'b0; start = 1'b1;
    push("b_state_rs", 1); push("b_go_rs", 0); push("b_score_rs", 0); push("b_secs_rs", 3);
    step(1);
    pop_cmp(32'(state)); pop_cmp(32'(game_over)); pop_cmp(32'(score)); pop_cmp(32'(secs_left));
    start = 1'b0; step(1);
    start = 1'b1;
    push("b_state_ign", 1); push("b_secs_ign", 3); step(1); pop_cmp(32'(state)); pop_cmp(32'(secs_left));
    start = 1'b0;
    // magazine and reload
    reset = 1'b0; step(1); reset = 1'b1;
    fire = 1'b1; push("c_shot1", 1); push("c_ammo1", 1); step(1); pop_cmp(32'(shot_pulse)); pop_cmp(32'(ammo));
    push("c_shot_held", 0); push("c_ammo_held", 1); step(1); pop_cmp(32'(shot_pulse)); pop_cmp(32'(ammo));
    fire = 1'b0; step(1);
    fire = 1'b1; push("c_shot2", 1); push("c_ammo2", 0); step(1); pop_cmp(32'(shot_pulse)); pop_cmp(32'(ammo));
    fire = 1'b0; step(1);
    fire = 1'b1; push("c_shot_empty", 0); push("c_ammo_empty", 0); step(1); pop_cmp(32'(shot_pulse)); pop_cmp(32'(ammo));
    fire = 1'b0; reload = 1'b1; push("c_ammo_reload", 2); step(1); pop_cmp(32'(ammo));
    fire = 1'b1; push("c_shot_suppr", 0); push("c_ammo_suppr", 2); step(1); pop_cmp(32'(shot_pulse)); pop_cmp(32'(ammo));
    fire = 1'b0; reload = 1'b0;
    // sound hold, hit retrigger, shot during hit tone
    reset = 1'b0; step(1); reset = 1'b1;
    fire = 1'b1; push("d_tone_fire", 1); step(1); pop_cmp(32'(tone_sel));
    fire = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push("d_tone_decay", (i < 3) ? 1 : 0); step(1); pop_cmp(32'(tone_sel));
    end
    fire = 1'b1; push("d_tone_fire2", 1); step(1); pop_cmp(32'(tone_sel));
    fire = 1'b0; collision = 4'b0010; step(1);
    collision = 4'b0000; push("d_tone_hit", 2); push("d_score_hit", 1); step(1); pop_cmp(32'(tone_sel)); pop_cmp(32'(score));
    reload = 1'b1; push("d_tone_hold2", 2); step(1); pop_cmp(32'(tone_sel));
    reload = 1'b0; fire = 1'b1;
    push("d_shot_in_hit", 1); push("d_tone_stay2", 2); step(1); pop_cmp(32'(shot_pulse)); pop_cmp(32'(tone_sel));
    fire = 1'b0; push("d_tone_hold0", 2); step(1); pop_cmp(32'(tone_sel));
    push("d_tone_off", 0); step(1); pop_cmp(32'(tone_sel));
    // scoring: multi-hit, held collision, saturation, simultaneous shot and hit
    reset = 1'b0; step(1); reset = 1'b1;
    collision = 4'b0101; step(1);
    collision = 4'b0000; push("e_score_two", 2); step(1); pop_cmp(32'(score));
    collision = 4'b0001; push("e_score_held", 2); step(16); pop_cmp(32'(score));
    collision = 4'b0000; push("e_score_fall", 3); step(1); pop_cmp(32'(score));
    collision = 4'b1111; step(1);
    collision = 4'b0000; push("e_score_sat", 3); step(1); pop_cmp(32'(score));
    collision = 4'b0100; step(1);
    collision = 4'b0000; fire = 1'b1;
    push("e_shot_sim", 1); push("e_tone_sim", 2); push("e_ammo_sim", 1);
    step(1);
    pop_cmp(32'(shot_pulse)); pop_cmp(32'(tone_sel)); pop_cmp(32'(ammo));
    fire = 1'b0;
    push("e_state_over", 2); push("e_ammo_over", 1); step(7); pop_cmp(32'(state)); pop_cmp(32'(ammo));
    start = 1'b1;
    push("e_state_rs", 1); push("e_ammo_rs", 2); push("e_score_rs", 0); push("e_secs_rs", 3);
    step(1);
    pop_cmp(32'(state)); pop_cmp(32'(ammo)); pop_cmp(32'(score)); pop_cmp(32'(secs_left));
    start = 1'b0;
    // reset mid-round, mid-sound
    step(3);
    fire = 1'b1; push("f_ammo_pre", 1); push("f_tone_pre", 1); step(1); pop_cmp(32'(ammo)); pop_cmp(32'(tone_sel));
    reset = 1'b0; fire = 1'b0;
    push("f_state", 1); push("f_ammo", 2); push("f_secs", 3); push("f_tone", 0); push("f_shot", 0); push("f_go", 0);
    step(1);
    pop_cmp(32'(state)); pop_cmp(32'(ammo)); pop_cmp(32'(secs_left)); pop_cmp(32'(tone_sel));
    pop_cmp(32'(shot_pulse)); pop_cmp(32'(game_over));
    // AUTO_START=0 instance: start held through reset release
    start = 1'b1; push("g_state_rst", 0); step(1); pop_cmp(32'(state0));
    reset0 = 1'b1; push("g_state_play", 1); push("g_secs_play", 3); step(1); pop_cmp(32'(state0)); pop_cmp(32'(secs_left0));
    fire = 1'b1; push("g_ammo_shot", 1); step(1); pop_cmp(32'(ammo0));
    reset0 = 1'b0; fire = 1'b0;
    push("g_state_rst2", 0); push("g_ammo_rst2", 2); push("g_go_rst2", 0); push("g_tone_rst2", 0);
    step(1);
    pop_cmp(32'(state0)); pop_cmp(32'(ammo0)); pop_cmp(32'(game_over0)); pop_cmp(32'(tone_sel0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/game_session_ctrl.md
# game_session_ctrl

Parametrised game-session controller for the duck-hunt design. It owns round state, the round countdown, the magazine (ammo) counter with reload, score accumulation from per-duck collision signals, and the sound-event selector. It sits between the input buttons and collision comparators on one side, and the gun/shot builder, LEDs and sound ROM addressing on the other. It generalises the session logic to N ducks, configurable magazine and round length, multi-hit scoring, explicit round states and restart.

## Interface
Parameters:
- NUM_DUCKS, 4, number of collision channels
- MAG_SIZE, 4, magazine capacity (1..2^AMMO_W-1)
- AMMO_W, 3, ammo counter width
- ROUND_SECS, 30, round length in seconds (1..255)
- TICKS_PER_SEC, 24000000, clk cycles per second
- TICK_W, 25, tick counter width
- SCORE_W, 8, score width
- SOUND_HOLD, 2000000, cycles a sound event is held
- HOLD_W, 21, hold counter width
- AUTO_START, 1, 1: reset leaves block in PLAY; 0: in IDLE

Ports:
- clk  in  1  game clock (vga_clk domain)
- reset  in  1  synchronous, active-low reset
- start  in  1  level; rising edge starts/restarts a round
- fire  in  1  level, pre-debounced trigger
- reload  in  1  level, refill magazine
- collision  in  NUM_DUCKS  per-duck collision levels
- state  out  2  0=IDLE, 1=PLAY, 2=OVER
- game_over  out  1  high in OVER
- shot_pulse  out  1  one-cycle pulse per accepted shot
- ammo  out  AMMO_W  rounds left
- score  out  SCORE_W  saturating hit count
- secs_left  out  8  seconds remaining
- tone_sel  out  2  0=silent, 1=fire tone, 2=hit tone

## Operation
- All outputs registered. Edge detectors: fire_d, start_d, coll_d[NUM_DUCKS-1:0] update every cycle in every state (prevents spurious edges on entering PLAY).
- States: IDLE -> PLAY on start rise. PLAY -> OVER on the cycle secs_left reaches 0. OVER -> PLAY on start rise. PLAY ignores start.
- Entering PLAY (from any state): ammo=MAG_SIZE, score=0, secs_left=ROUND_SECS, tick=0, tone_sel=0.
- Timer (PLAY only): tick counts 0..TICKS_PER_SEC-1; on wrap secs_left decrements; when decrement yields 0, state<=OVER same edge.
- Shot (PLAY only): fire rise with ammo>0 and reload low -> shot_pulse=1, ammo-1. fire rise with ammo==0: no pulse, no change. fire held high does not repeat.
- Reload (PLAY only): reload high -> ammo=MAG_SIZE each cycle; same-cycle fire rise is suppressed (no pulse, no decrement).
- Score (PLAY only): hits = popcount of channels with coll_d=1, collision=0 (falling edge = duck left the shot). score += hits, saturating at 2^SCORE_W-1.
- Sound (PLAY only): hits>0 -> tone_sel=2, hold counter=SOUND_HOLD-1. Else shot_pulse event with tone_sel!=2 -> tone_sel=1, reload hold. Hold decrements each cycle; at 0 while tone nonzero, tone_sel=0 next cycle. Retrigger reloads hold. Leaving PLAY forces tone_sel=0.
- IDLE/OVER: ammo, score, secs_left frozen; shot_pulse=0.

## Timing
- Reset (reset=0 sampled at clk edge): state=AUTO_START?PLAY:IDLE, game_over=0, shot_pulse=0, ammo=MAG_SIZE, score=0, secs_left=ROUND_SECS, tone_sel=0, tick=0, all edge registers=0 (an input already high at release produces a rising edge on the first cycle).
- Reset overrides everything, including mid-round and mid-sound-hold.
- Input-to-output latency: 1 cycle (edge sampled at edge N, outputs visible after edge N).
- game_over asserts the same edge state becomes OVER; a hit and the final tick in the same cycle still score.
- Simultaneous fire rise and hits: both counted; tone_sel=2.

## Test plan
- Params TICKS_PER_SEC=10, ROUND_SECS=3, AUTO_START=1: release reset, idle inputs -> secs_left 3,2,1,0 at cycles 10,20,30; state=OVER and game_over=1 at cycle 30.
- MAG_SIZE=2: three fire pulses -> shot_pulse twice, ammo 2->1->0, third pulse no pulse; reload high 1 cycle -> ammo=2; fire rise with reload high -> no pulse, ammo=2.
- collision[0] and collision[2] fall in the same cycle -> score +2; collision held high 100 cycles -> 0 until it falls; SCORE_W=2 with 5 hits -> score=3.
- SOUND_HOLD=4: shot -> tone_sel=1 for 4 cycles then 0; hit during fire tone -> tone_sel=2, hold restarts; shot during hit tone -> stays 2.
- OVER then start rise -> PLAY, score=0, ammo=MAG_SIZE, secs_left=ROUND_SECS; collisions/fire during OVER change nothing.
- AUTO_START=0: reset -> state=IDLE; start held high through reset release -> PLAY one cycle later; reset=0 mid-round -> all outputs at reset values next edge.
